// File: rtl/da_pkg.sv
// Shared types and default widths for the DAC waveform sequencer.
package da_pkg;

  localparam int unsigned PhaseWDef = 32;
  localparam int unsigned AddrWDef  = 10;
  localparam int unsigned DataWDef  = 10;
  localparam int unsigned AmpWDef   = 8;

  localparam int unsigned DAC_MIDSCALE = 512;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPend
  } da_state_e;

endpackage

// File: rtl/da_amp_scale.sv
// Offset-binary amplitude scaler with registered DAC output.
// Idle (valid low) drives midscale so the DAC rests at zero signal.
module da_amp_scale
  import da_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned AMP_W  = AmpWDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [AMP_W-1:0]  amp,
  output logic [DATA_W-1:0] da_data
);

  localparam int unsigned ProdW = DATA_W + AMP_W + 1;
  localparam logic [DATA_W-1:0] Mid = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0]  smp;
  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] shifted;
  logic [DATA_W-1:0]       da_d;
  logic [DATA_W-1:0]       da_q;

  always_comb begin
    smp     = $signed({1'b0, rd_data}) - $signed({1'b0, Mid});
    prod    = ProdW'(smp) * ProdW'($signed({1'b0, amp}));
    shifted = prod >>> AMP_W;
    // |gain| < 1, so the rescaled sample always lands back inside the DAC range
    da_d    = valid ? DATA_W'(shifted) + Mid : Mid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_q <= Mid;
    end else begin
      da_q <= da_d;
    end
  end

  assign da_data = da_q;

endmodule

// File: rtl/da_wave_ctrl.sv
// DDS sequencer: phase accumulator addresses the waveform ROM; new configs swap in on a wrap.
// Define DA_WAVE_CTRL_BURST_EN to add cfg_burst/done for auto-stop after N periods.
module da_wave_ctrl
  import da_pkg::*;
#(
  parameter int unsigned PHASE_W = PhaseWDef,
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned AMP_W   = AmpWDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fword,
  input  logic [ADDR_W-1:0]  cfg_poff,
  input  logic [AMP_W-1:0]   cfg_amp,
`ifdef DA_WAVE_CTRL_BURST_EN
  input  logic [15:0]        cfg_burst,
  output logic               done,
`endif
  input  logic               start,
  input  logic               stop,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               da_clk,
  output logic [DATA_W-1:0]  da_data,
  output logic               busy,
  output logic               wrap
);

  typedef struct packed {
    logic [PHASE_W-1:0] fword;
    logic [ADDR_W-1:0]  poff;
    logic [AMP_W-1:0]   amp;
`ifdef DA_WAVE_CTRL_BURST_EN
    logic [15:0]        burst;
`endif
  } cfg_t;

  localparam cfg_t CfgRst = '{amp: '1, default: '0};

  da_state_e          state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  cfg_t               act_q, act_d;
  cfg_t               sh_q, sh_d;
  cfg_t               cfg_in;
  logic               wrap_q, wrap_d;
  logic               vld_q, vld_d;
  logic [AMP_W-1:0]   amp_p_q, amp_p_d;
  logic [PHASE_W:0]   sum;
  logic               hs;
  logic               auto_stop;
`ifdef DA_WAVE_CTRL_BURST_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               done_q, done_d;
`endif

  always_comb begin
    cfg_in.fword = cfg_fword;
    cfg_in.poff  = cfg_poff;
    cfg_in.amp   = cfg_amp;
`ifdef DA_WAVE_CTRL_BURST_EN
    cfg_in.burst = cfg_burst;
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    act_d     = act_q;
    sh_d      = sh_q;
    wrap_d    = 1'b0;
    auto_stop = 1'b0;
    hs        = cfg_valid && (state_q != StPend);
    sum       = {1'b0, acc_q} + {1'b0, act_q.fword};
    vld_d     = busy;
    amp_p_d   = act_q.amp;
`ifdef DA_WAVE_CTRL_BURST_EN
    cnt_d     = cnt_q;
    done_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (hs) act_d = cfg_in;
        // act_d already holds a same-cycle handshake, so that config drives this start
        if (start && !stop) begin
          state_d = StRun;
          acc_d   = {act_d.poff, {(PHASE_W-ADDR_W){1'b0}}};
`ifdef DA_WAVE_CTRL_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      StRun, StPend: begin
        acc_d  = sum[PHASE_W-1:0];
        wrap_d = sum[PHASE_W];
`ifdef DA_WAVE_CTRL_BURST_EN
        if (sum[PHASE_W]) cnt_d = cnt_q + 16'd1;
        auto_stop = sum[PHASE_W] && (act_q.burst != '0) && (cnt_d == act_q.burst);
        done_d    = auto_stop && !stop;
`endif
        if (stop || auto_stop) begin
          state_d = StIdle;
          // an accepted config is never dropped on the way to idle
          if (state_q == StPend) act_d = sh_q;
          else if (hs)           act_d = cfg_in;
        end else if (state_q == StPend && sum[PHASE_W]) begin
          state_d = StRun;
          act_d   = sh_q;
          acc_d   = {sh_q.poff, {(PHASE_W-ADDR_W){1'b0}}};
`ifdef DA_WAVE_CTRL_BURST_EN
          cnt_d   = '0;
`endif
        end else if (state_q == StRun && hs) begin
          state_d = StPend;
          sh_d    = cfg_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      act_q   <= CfgRst;
      sh_q    <= '0;
      wrap_q  <= 1'b0;
      vld_q   <= 1'b0;
      amp_p_q <= '1;
`ifdef DA_WAVE_CTRL_BURST_EN
      cnt_q   <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      act_q   <= act_d;
      sh_q    <= sh_d;
      wrap_q  <= wrap_d;
      vld_q   <= vld_d;
      amp_p_q <= amp_p_d;
`ifdef DA_WAVE_CTRL_BURST_EN
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`endif
    end
  end

  assign rd_addr   = acc_q[PHASE_W-1 -: ADDR_W];
  assign busy      = (state_q != StIdle);
  assign cfg_ready = (state_q != StPend);
  assign wrap      = wrap_q;
  assign da_clk    = ~clk;
`ifdef DA_WAVE_CTRL_BURST_EN
  assign done      = done_q;
`endif

  // vld_q/amp_p_q line up with rd_data, one cycle behind rd_addr
  da_amp_scale #(
    .DATA_W (DATA_W),
    .AMP_W  (AMP_W)
  ) u_amp_scale (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (vld_q),
    .rd_data (rd_data),
    .amp     (amp_p_q),
    .da_data (da_data)
  );

endmodule

// File: tb/tb_da_wave_ctrl.sv
// Bench for da_wave_ctrl: directed and randomized playback checked against a cycle model.
module tb_da_wave_ctrl;
  import da_pkg::*;

  localparam int unsigned PW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 10;
  localparam int unsigned MW    = 8;
  localparam int unsigned Shift = PW - AW;
  localparam longint      Mod   = 64'h1_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [PW-1:0] cfg_fword = '0;
  logic [AW-1:0] cfg_poff = '0;
  logic [MW-1:0] cfg_amp = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          da_clk;
  logic [DW-1:0] da_data;
  logic          busy;
  logic          wrap;
`ifdef DA_WAVE_CTRL_BURST_EN
  logic [15:0]   cfg_burst = '0;
  logic          done;
`endif

  logic [DW-1:0] rom [1024];

  int n_pass = 0;
  int n_tot  = 0;

  // reference model state
  bit     m_busy, m_pend, m_wrap;
  longint m_acc, m_F, s_F;
  int     m_P, m_A, s_P, s_A;
  bit     p_busy;
  int     p_addr, p_amp, e_da;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rom[rd_addr];

  da_wave_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_fword (cfg_fword),
    .cfg_poff  (cfg_poff),
    .cfg_amp   (cfg_amp),
`ifdef DA_WAVE_CTRL_BURST_EN
    .cfg_burst (cfg_burst),
    .done      (done),
`endif
    .start     (start),
    .stop      (stop),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .da_clk    (da_clk),
    .da_data   (da_data),
    .busy      (busy),
    .wrap      (wrap)
  );

  function automatic int scale(int d, int a);
    int s = d - int'(DAC_MIDSCALE);
    return ((s * a) >>> MW) + int'(DAC_MIDSCALE);
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_wrap = 0; m_acc = 0;
    m_F = 0; m_P = 0; m_A = 255; s_F = 0; s_P = 0; s_A = 0;
    p_busy = 0; p_addr = 0; p_amp = 255; e_da = int'(DAC_MIDSCALE);
  endtask

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit hs;
    longint nxt;
    e_da   = p_busy ? scale(int'(rom[p_addr]), p_amp) : int'(DAC_MIDSCALE);
    p_busy = m_busy;
    p_addr = int'(m_acc >> Shift);
    p_amp  = m_A;
    hs     = cfg_valid && !m_pend;
    m_wrap = 0;
    if (!m_busy) begin
      if (hs) begin m_F = cfg_fword; m_P = cfg_poff; m_A = cfg_amp; end
      if (start && !stop) begin m_busy = 1; m_acc = longint'(m_P) << Shift; end
    end else begin
      nxt    = m_acc + m_F;
      m_wrap = (nxt >= Mod);
      m_acc  = nxt % Mod;
      if (stop) begin
        m_busy = 0;
        if (m_pend) begin m_F = s_F; m_P = s_P; m_A = s_A; m_pend = 0; end
        else if (hs) begin m_F = cfg_fword; m_P = cfg_poff; m_A = cfg_amp; end
      end else if (m_pend && m_wrap) begin
        m_F = s_F; m_P = s_P; m_A = s_A; m_pend = 0;
        m_acc = longint'(m_P) << Shift;
      end else if (hs) begin
        s_F = cfg_fword; s_P = cfg_poff; s_A = cfg_amp; m_pend = 1;
      end
    end
  endtask

  task automatic check_cycle();
    chk("rd_addr", rd_addr, m_acc >> Shift);
    chk("wrap", wrap, m_wrap);
    chk("busy", busy, m_busy);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("da_data", da_data, e_da);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic set_cfg(input logic [PW-1:0] f, input logic [AW-1:0] p, input logic [MW-1:0] a);
    cfg_valid = 1'b1; cfg_fword = f; cfg_poff = p; cfg_amp = a;
  endtask

  task automatic stop_and_drain();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (4) tick();
    chk("idle_busy", busy, 0);
    chk("idle_midscale", da_data, DAC_MIDSCALE);
  endtask

  initial begin
    int wraps, wcyc;
    bit seen;
    logic [PW-1:0] rf;
    for (int i = 0; i < 1024; i++) rom[i] = DW'($urandom_range(0, 1023));
    rom[256] = 10'd1023;
    rom[258] = 10'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_da", da_data, 512);
    chk("rst_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_wrap", wrap, 0);
    chk("da_clk_inv", da_clk, !clk);
    rst_n = 1'b1;

    // unit step, full gain: one wrap per 1024 clocks
    set_cfg(32'h0040_0000, 10'd0, 8'd255); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wraps = 0; wcyc = 0;
    for (int n = 2; n <= 1030; n++) begin
      tick();
      if (wrap) begin wraps++; wcyc = n; end
    end
    chk("wrap_count", wraps, 1);
    chk("wrap_cycle", wcyc, 1025);
    stop_and_drain();

    // step 2 from address 256, half gain
    set_cfg(32'h0080_0000, 10'd256, 8'd128); tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("poff_addr", rd_addr, 256);
    tick();
    tick(); chk("amp128_max", da_data, 767);
    tick(); chk("amp128_min", da_data, 256);
    repeat (20) tick();
    stop_and_drain();

    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 0);

    // config with start, then a shadowed config that swaps in on the wrap
    set_cfg(32'h0040_0000, 10'd1000, 8'd200); start = 1'b1; tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfg_with_start", rd_addr, 1000);
    repeat (5) tick();
    set_cfg(32'h0100_0000, 10'd40, 8'd100); tick(); cfg_valid = 1'b0;
    chk("pend_ready", cfg_ready, 0);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (wrap) begin seen = 1; chk("swap_addr", rd_addr, 40); end
    end
    chk("swap_seen", seen, 1);
    tick(); chk("step4", rd_addr, 44);
    chk("ready_back", cfg_ready, 1);
    repeat (10) tick();
    stop_and_drain();

    // zero step: PEND never resolves; stop promotes the shadow
    set_cfg(32'h0, 10'd7, 8'd255); start = 1'b1; tick(); cfg_valid = 1'b0; start = 1'b0;
    repeat (3) tick();
    set_cfg(32'h0040_0000, 10'd100, 8'd60); tick(); cfg_valid = 1'b0;
    repeat (20) tick();
    chk("frozen_addr", rd_addr, 7);
    chk("frozen_pend", cfg_ready, 0);
    stop_and_drain();
    start = 1'b1; tick(); start = 1'b0;
    chk("shadow_applied", rd_addr, 100);
    repeat (10) tick();
    stop_and_drain();

    // randomized configs, mid-run reconfig and stray start pulses
    for (int k = 0; k < 6; k++) begin
      rf = $urandom;
      set_cfg(rf, AW'($urandom_range(0, 1023)), MW'($urandom_range(0, 255)));
      start = 1'b1; tick(); cfg_valid = 1'b0; start = 1'b0;
      for (int n = 0; n < 80; n++) begin
        if (n == 10) start = 1'b1;
        if (n == 30) set_cfg($urandom | 32'h0100_0000, AW'($urandom_range(0, 1023)),
                             MW'($urandom_range(0, 255)));
        tick();
        start = 1'b0; cfg_valid = 1'b0;
      end
      stop_and_drain();
    end

    // asynchronous reset in the middle of playback
    set_cfg(32'h0123_4567, 10'd300, 8'd255); start = 1'b1; tick();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_da", da_data, 512);
    chk("arst_addr", rd_addr, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_ready", cfg_ready, 1);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    stop_and_drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
